// File: rtl/core_mem_arbiter_pkg.sv
// Shared types and helpers for the core memory-port arbiter:
// FSM state and grant encodings, default line size, line-base masking.
package core_mem_arbiter_pkg;

  localparam int DEFAULT_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IC_XFER = 2'd1,
    ST_DC_XFER = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } grant_t;

  function automatic logic [31:0] line_base(input logic [31:0] addr, input int ofs_bits);
    line_base = addr & ~((32'd1 << ofs_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Bundle of I-cache, D-cache and memory-port signals around the arbiter.
// master = the arbiter itself, slave = caches plus memory.
interface core_mem_arbiter_if
  import core_mem_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS
);
  logic                    ic_req;
  logic [31:0]             ic_addr;
  logic                    ic_ready;
  logic [32*LINE_WORDS-1:0] ic_line;
  logic                    dc_req;
  logic                    dc_we;
  logic [31:0]             dc_addr;
  logic [32*LINE_WORDS-1:0] dc_wline;
  logic                    dc_ready;
  logic [32*LINE_WORDS-1:0] dc_rline;
  logic                    mem_req;
  logic                    mem_we;
  logic [31:0]             mem_addr;
  logic [31:0]             mem_wdata;
  logic                    mem_ready;
  logic [31:0]             mem_rdata;
  logic                    arb_busy;

  modport master (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wline, mem_ready, mem_rdata,
    output ic_ready, ic_line, dc_ready, dc_rline, mem_req, mem_we, mem_addr, mem_wdata, arb_busy
  );

  modport slave (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wline, mem_ready, mem_rdata,
    input  ic_ready, ic_line, dc_ready, dc_rline, mem_req, mem_we, mem_addr, mem_wdata, arb_busy
  );
endinterface

// File: rtl/core_mem_arbiter_line_buf.sv
// Line buffer shared by both requesters: whole-line load for write-backs,
// per-word capture for fills, and a word-select read mux.
module mem_line_buf
  import core_mem_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_load,
  input  logic [32*LINE_WORDS-1:0] i_line,
  input  logic                     i_we,
  input  logic [IDX_W-1:0]         i_widx,
  input  logic [31:0]              i_wdata,
  input  logic [IDX_W-1:0]         i_ridx,
  output logic [31:0]              o_rdata,
  output logic [32*LINE_WORDS-1:0] o_line
);
  logic [31:0] r_words [LINE_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < LINE_WORDS; i++) r_words[i] <= 32'd0;
    end else if (i_load) begin
      for (int i = 0; i < LINE_WORDS; i++) r_words[i] <= i_line[32*i +: 32];
    end else if (i_we) begin
      r_words[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_words[i_ridx];

  always_comb begin
    o_line = {(32*LINE_WORDS){1'b0}};
    for (int i = 0; i < LINE_WORDS; i++) o_line[32*i +: 32] = r_words[i];
  end
endmodule

// File: rtl/core_mem_arbiter.sv
// Arbitrates the single external memory port between I-cache fills and
// D-cache fills/write-backs, issuing each grant as a LINE_WORDS-beat burst.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  parameter int OFS_BITS   = $clog2(LINE_WORDS) + 2
) (
  input  logic               clock,
  input  logic               reset,
  core_mem_arbiter_if.master bus
);
  localparam int                BEAT_W    = $clog2(LINE_WORDS);
  localparam int                LINE_W    = 32 * LINE_WORDS;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORDS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  arb_state_t        r_state;
  grant_t            r_last_grant;
  logic [BEAT_W-1:0] r_beat;
  logic [31:0]       r_base;
  logic              r_we;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_ic_ready;
  logic              r_dc_ready;
  logic [LINE_W-1:0] r_ic_line;
  logic [LINE_W-1:0] r_dc_rline;
  logic              r_busy;

  logic              w_grant;
  logic              w_pick_dc;
  logic              w_xfer;
  logic              w_beat_done;
  logic              w_buf_load;
  logic              w_buf_we;
  logic [BEAT_W-1:0] w_beat_nxt;
  logic [31:0]       w_buf_rword;
  logic [LINE_W-1:0] w_buf_line;
  logic [LINE_W-1:0] w_fill_line;

  // On a tie the requester not served last wins.
  always_comb begin
    w_grant     = bus.ic_req | bus.dc_req;
    w_pick_dc   = bus.dc_req & (~bus.ic_req | (r_last_grant == GNT_IC));
    w_xfer      = (r_state == ST_IC_XFER) | (r_state == ST_DC_XFER);
    w_beat_done = w_xfer & bus.mem_ready;
    w_beat_nxt  = r_beat + BEAT_ONE;
    w_buf_load  = (r_state == ST_IDLE) & w_grant & w_pick_dc & bus.dc_we;
    w_buf_we    = w_beat_done & ~r_we;
    w_fill_line = w_buf_line;
    w_fill_line[32*r_beat +: 32] = bus.mem_rdata;
  end

  mem_line_buf #(.LINE_WORDS(LINE_WORDS)) u_line_buf (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_load  (w_buf_load),
    .i_line  (bus.dc_wline),
    .i_we    (w_buf_we),
    .i_widx  (r_beat),
    .i_wdata (bus.mem_rdata),
    .i_ridx  (w_beat_nxt),
    .o_rdata (w_buf_rword),
    .o_line  (w_buf_line)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GNT_IC;
      r_beat       <= {BEAT_W{1'b0}};
      r_base       <= 32'd0;
      r_we         <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_ic_ready   <= 1'b0;
      r_dc_ready   <= 1'b0;
      r_ic_line    <= {LINE_W{1'b0}};
      r_dc_rline   <= {LINE_W{1'b0}};
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_beat    <= {BEAT_W{1'b0}};
            r_mem_req <= 1'b1;
            r_busy    <= 1'b1;
            if (w_pick_dc) begin
              r_state      <= ST_DC_XFER;
              r_last_grant <= GNT_DC;
              r_base       <= line_base(bus.dc_addr, OFS_BITS);
              r_mem_addr   <= line_base(bus.dc_addr, OFS_BITS);
              r_we         <= bus.dc_we;
              r_mem_we     <= bus.dc_we;
              r_mem_wdata  <= bus.dc_we ? bus.dc_wline[31:0] : 32'd0;
            end else begin
              r_state      <= ST_IC_XFER;
              r_last_grant <= GNT_IC;
              r_base       <= line_base(bus.ic_addr, OFS_BITS);
              r_mem_addr   <= line_base(bus.ic_addr, OFS_BITS);
              r_we         <= 1'b0;
              r_mem_we     <= 1'b0;
              r_mem_wdata  <= 32'd0;
            end
          end
        end
        ST_IC_XFER, ST_DC_XFER: begin
          if (bus.mem_ready) begin
            if (r_beat == BEAT_LAST) begin
              r_state     <= ST_RESP;
              r_mem_req   <= 1'b0;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= 32'd0;
              r_mem_wdata <= 32'd0;
              if (r_state == ST_IC_XFER) begin
                r_ic_ready <= 1'b1;
                r_ic_line  <= w_fill_line;
              end else begin
                r_dc_ready <= 1'b1;
                if (!r_we) r_dc_rline <= w_fill_line;
              end
            end else begin
              // Next beat is presented immediately so zero-wait bursts have no bubble.
              r_beat      <= w_beat_nxt;
              r_mem_addr  <= r_base + (32'(w_beat_nxt) << 2);
              r_mem_wdata <= r_we ? w_buf_rword : 32'd0;
            end
          end
        end
        ST_RESP: begin
          r_state    <= ST_IDLE;
          r_ic_ready <= 1'b0;
          r_dc_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ic_ready  = r_ic_ready;
  assign bus.ic_line   = r_ic_line;
  assign bus.dc_ready  = r_dc_ready;
  assign bus.dc_rline  = r_dc_rline;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.arb_busy  = r_busy;
endmodule
